// File: rtl/line_endpoint_animator.sv
// Bouncing-endpoint line animator: erases the oldest trail line, moves both
// endpoints with edge reflection, then draws the new line via start/done.
module line_endpoint_animator #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int TRAIL       = 4,
  parameter int HOLD_CYCLES = 1000000,
  parameter int P0_X        = 0,
  parameter int P0_Y        = 0,
  parameter int P1_X        = 639,
  parameter int P1_Y        = 479,
  parameter int V0_X        = 3,
  parameter int V0_Y        = 2,
  parameter int V1_X        = -2,
  parameter int V1_Y        = -5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        done,
  output logic        start,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic        colour,
  output logic        busy
);
  // state       | meaning
  // IDLE        | parked, waiting for enable
  // ERASE_ISSUE | start pulse for erase of oldest trail line
  // ERASE_WAIT  | waiting for done on the erase
  // MOVE        | advance endpoints with reflection
  // DRAW_ISSUE  | start pulse for the new line, record it in the trail
  // DRAW_WAIT   | waiting for done on the draw
  // HOLD        | idle gap between animation steps
  typedef enum logic [2:0] {
    IDLE, ERASE_ISSUE, ERASE_WAIT, MOVE, DRAW_ISSUE, DRAW_WAIT, HOLD
  } state_t;

  localparam int PW = $clog2(TRAIL);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [10:0] MAX_X = 11'(SCREEN_W - 1);
  localparam logic [10:0] MAX_Y = 11'(SCREEN_H - 1);

  state_t state, state_nx;
  logic [10:0] p0x, p0y, p1x, p1y;
  logic [4:0]  v0x, v0y, v1x, v1y;
  logic [PW-1:0] ptr;
  logic [PW:0]   cnt;
  logic [HW-1:0] hold_cnt;
  logic [43:0]   trail [TRAIL];
  logic [15:0]   m0x, m0y, m1x, m1y;
  logic          full;

  // Returns {new velocity, new position}; reflection clamps to the edge.
  function automatic logic [15:0] step(input logic [10:0] p, input logic [4:0] v,
                                       input logic [10:0] maxv);
    logic signed [11:0] n;
    n = $signed({1'b0, p}) + $signed({{7{v[4]}}, v});
    if (n < 0) step = {-v, 11'd0};
    else if (n > $signed({1'b0, maxv})) step = {-v, maxv};
    else step = {v, n[10:0]};
  endfunction

  assign m0x  = step(p0x, v0x, MAX_X);
  assign m0y  = step(p0y, v0y, MAX_Y);
  assign m1x  = step(p1x, v1x, MAX_X);
  assign m1y  = step(p1y, v1y, MAX_Y);
  assign full = (cnt == (PW+1)'(TRAIL));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (enable) state_nx = full ? ERASE_ISSUE : MOVE;
      ERASE_ISSUE: state_nx = ERASE_WAIT;
      ERASE_WAIT:  if (done) state_nx = MOVE;
      MOVE:        state_nx = DRAW_ISSUE;
      DRAW_ISSUE:  state_nx = DRAW_WAIT;
      DRAW_WAIT:   if (done) state_nx = HOLD;
      HOLD: begin
        if (hold_cnt == '0) begin
          if (!enable) state_nx = IDLE;
          else state_nx = full ? ERASE_ISSUE : MOVE;
        end
      end
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      start    <= 1'b0;
      colour   <= 1'b0;
      busy     <= 1'b0;
      {x0, y0, x1, y1} <= '0;
      p0x <= 11'(P0_X);
      p0y <= 11'(P0_Y);
      p1x <= 11'(P1_X);
      p1y <= 11'(P1_Y);
      v0x <= 5'(V0_X);
      v0y <= 5'(V0_Y);
      v1x <= 5'(V1_X);
      v1y <= 5'(V1_Y);
      ptr      <= '0;
      cnt      <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nx;
      start <= (state_nx == ERASE_ISSUE) || (state_nx == DRAW_ISSUE);
      busy  <= (state_nx != IDLE);
      if (state_nx == ERASE_ISSUE) begin
        {x0, y0, x1, y1} <= trail[ptr];
        colour <= 1'b0;
      end
      if (state == MOVE) begin
        {v0x, p0x} <= m0x;
        {v0y, p0y} <= m0y;
        {v1x, p1x} <= m1x;
        {v1y, p1y} <= m1y;
        {x0, y0, x1, y1} <= {m0x[10:0], m0y[10:0], m1x[10:0], m1y[10:0]};
        colour <= 1'b1;
      end
      if (state == DRAW_WAIT && done) begin
        ptr      <= (ptr == PW'(TRAIL - 1)) ? '0 : ptr + 1'b1;
        cnt      <= full ? cnt : cnt + 1'b1;
        hold_cnt <= HW'(HOLD_CYCLES - 1);
      end
      if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Trail storage carries no reset; the count decides what is valid.
  always_ff @(posedge clk) begin
    if (state == DRAW_ISSUE) trail[ptr] <= {p0x, p0y, p1x, p1y};
  end
endmodule

// File: tb/tb_line_endpoint_animator.sv
// Directed bench: main instance (TRAIL=2, HOLD=2) plus a bounce instance.
module tb_line_endpoint_animator;
  logic clk = 0, reset = 0;
  logic enable = 0, done = 0, enable_b = 0, done_b = 0;
  logic start, colour, busy, start_b, colour_b, busy_b;
  logic [10:0] x0, y0, x1, y1, bx0, by0, bx1, by1;
  int checks = 0, failures = 0;
  bit sel = 0;

  always #5 clk = ~clk;

  line_endpoint_animator #(.TRAIL(2), .HOLD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .done(done), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour(colour), .busy(busy));

  line_endpoint_animator #(.TRAIL(2), .HOLD_CYCLES(2), .P0_X(638), .V0_X(3),
                           .P1_X(1), .V1_X(-3)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .done(done_b), .start(start_b),
    .x0(bx0), .y0(by0), .x1(bx1), .y1(by1), .colour(colour_b), .busy(busy_b));

  wire        s_start  = sel ? start_b : start;
  wire        s_colour = sel ? colour_b : colour;
  wire [43:0] s_pts    = sel ? {bx0, by0, bx1, by1} : {x0, y0, x1, y1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!s_start && n < 200);
    chk({tag, "_seen"}, s_start, 1);
  endtask

  task automatic expect_line(input string tag, input logic c,
                             input int ax, input int ay, input int bx, input int by);
    chk({tag, "_colour"}, s_colour, c);
    chk({tag, "_pts"}, s_pts, {11'(ax), 11'(ay), 11'(bx), 11'(by)});
  endtask

  task automatic give_done();
    @(negedge clk);
    chk("start_width", s_start, 0);
    if (sel) done_b = 1; else done = 1;
    @(negedge clk);
    done = 0; done_b = 0;
  endtask

  initial begin
    int n;
    bit seen, moved;
    logic [43:0] snap;
    #12;
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_colour", colour, 0);
    chk("rst_pts", {x0, y0, x1, y1}, 0);
    @(negedge clk); reset = 1;
    @(negedge clk); enable = 1;

    wait_start("d1", n);
    chk("d1_latency", n, 2);
    chk("d1_busy", busy, 1);
    expect_line("d1", 1, 3, 2, 637, 474);
    give_done();
    wait_start("d2", n);
    expect_line("d2", 1, 6, 4, 635, 469);
    give_done();

    wait_start("e3", n);
    expect_line("e3", 0, 3, 2, 637, 474);
    give_done();
    wait_start("d3", n);
    expect_line("d3", 1, 9, 6, 633, 464);

    // Stall the drawer for 50 cycles in DRAW_WAIT.
    snap = {x0, y0, x1, y1};
    seen = 0; moved = 0;
    repeat (50) begin
      @(negedge clk);
      if (start) seen = 1;
      if ({x0, y0, x1, y1} !== snap || colour !== 1'b1) moved = 1;
    end
    chk("stall_no_start", seen, 0);
    chk("stall_stable", moved, 0);
    // done held through the first HOLD cycle must be ignored there.
    @(negedge clk); done = 1;
    @(negedge clk); chk("hold_busy", busy, 1);
    @(negedge clk); done = 0;
    wait_start("e4", n);
    chk("hold_len", n, 1);
    expect_line("e4", 0, 6, 4, 635, 469);

    @(negedge clk); enable = 0;
    @(negedge clk); done = 1;
    @(negedge clk); done = 0;
    wait_start("d4", n);
    expect_line("d4", 1, 12, 8, 631, 459);
    give_done();
    seen = 0;
    repeat (8) begin @(negedge clk); if (start) seen = 1; end
    chk("park_no_start", seen, 0);
    chk("park_busy", busy, 0);
    enable = 1;
    wait_start("e5", n);
    chk("e5_latency", n, 1);
    expect_line("e5", 0, 9, 6, 633, 464);
    give_done();
    wait_start("d5", n);
    expect_line("d5", 1, 15, 10, 629, 454);

    @(negedge clk); reset = 0;
    #1;
    chk("arst_start", start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pts", {x0, y0, x1, y1}, 0);
    @(negedge clk); reset = 1;
    wait_start("d6", n);
    chk("d6_latency", n, 2);
    expect_line("d6", 1, 3, 2, 637, 474);
    give_done();
    enable = 0;

    sel = 1;
    enable_b = 1;
    wait_start("b1", n);
    expect_line("b1", 1, 639, 2, 0, 474);
    give_done();
    wait_start("b2", n);
    expect_line("b2", 1, 636, 4, 3, 469);
    give_done();
    enable_b = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/line_endpoint_animator.md
Name: line_endpoint_animator

Overview:
- Upstream command source for the line drawer. Animates two bouncing endpoints across the screen and keeps a ring-buffer trail of the last TRAIL lines.
- Each animation step erases the oldest trail line (colour 0), moves the endpoints with edge reflection, then draws the new line (colour 1).
- Each line goes out as one start/done transaction with the line-drawer control unit.

Parameters:
- SCREEN_W, 640, visible width; x range 0..SCREEN_W-1
- SCREEN_H, 480, visible height; y range 0..SCREEN_H-1
- TRAIL, 4, lines kept on screen (ring-buffer depth, 2..16)
- HOLD_CYCLES, 1000000, idle cycles between steps (>=1)
- P0_X/P0_Y/P1_X/P1_Y, 0/0/639/479, reset endpoint positions
- V0_X/V0_Y/V1_X/V1_Y, +3/+2/-2/-5, reset velocities (signed 5-bit, magnitude 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run animation while high
- done  in  1  line drawer finished the current line
- start  out  1  one-cycle pulse: line request valid
- x0, y0, x1, y1  out  11 each  line endpoints to line drawer
- colour  out  1  1 = draw, 0 = erase
- busy  out  1  high whenever not in IDLE

Behaviour:
- Reset (async, reset low):
  - state = IDLE; start = 0, colour = 0, busy = 0; x0/y0/x1/y1 = 0.
  - Endpoints and velocities take their parameter values.
  - Trail count = 0, write pointer = 0, hold counter = 0.
  - Reset mid-transaction abandons the line. Pixels already drawn are not cleaned up.
- States: IDLE, ERASE_ISSUE, ERASE_WAIT, MOVE, DRAW_ISSUE, DRAW_WAIT, HOLD.
- IDLE: when enable = 1, go to ERASE_ISSUE if trail count == TRAIL, else MOVE.
- ERASE_ISSUE (1 cycle):
  - Drive the endpoints stored at the write pointer with colour = 0.
  - start = 1 for this cycle only; go to ERASE_WAIT.
- ERASE_WAIT: hold x0..y1 and colour stable; on done = 1, go to MOVE.
- MOVE (1 cycle), per axis independently, with n = p + v computed in 12-bit signed:
  - If n < 0: p = 0 and v = -v.
  - If n > MAX (SCREEN_W-1 or SCREEN_H-1): p = MAX and v = -v.
  - Otherwise p = n.
  - Go to DRAW_ISSUE.
- DRAW_ISSUE (1 cycle):
  - Drive the new endpoints with colour = 1 and start = 1.
  - Write the endpoints into the trail slot at the write pointer; go to DRAW_WAIT.
- DRAW_WAIT: outputs stable; on done = 1:
  - write pointer = (ptr + 1) mod TRAIL;
  - trail count increments, saturating at TRAIL;
  - go to HOLD and load the hold counter.
- HOLD:
  - Count HOLD_CYCLES cycles, then go to ERASE_ISSUE / MOVE by the same rule as IDLE.
  - If enable = 0 when the count expires, go to IDLE instead.
- Handshake rules:
  - start is never high two consecutive cycles.
  - done is sampled only in the *_WAIT states; done in any other state is ignored.
  - done may arrive the cycle after start. Minimum transaction length is 2 cycles.
- enable = 0 mid-step: the current erase/draw transaction and its step complete; the state machine parks in IDLE after HOLD. Trail state is retained, so re-enabling continues the sequence.
- Latency, from IDLE with enable rising and trail full: start (erase) asserts 1 cycle later. Not-full case: draw start asserts 2 cycles later (MOVE, then DRAW_ISSUE).
- Outputs are registered; endpoint outputs change only on ISSUE entry.

Test Plan:
1. Setup: reset low, then high; enable = 1; done returned 2 cycles after each start; HOLD_CYCLES = 2, TRAIL = 2.
   - Required: first start with colour = 1, endpoints (3,2)-(637,474).
   - Required: second draw at (6,4)-(635,469) with no erase before it.
2. Same setup, third step.
   - Required: erase start (colour 0) at (3,2)-(637,474).
   - Required: then a draw at (9,6)-(633,464).
3. Bounce: P0_X = 638, V0_X = +3.
   - Required: after MOVE, x0 = 639 and V0_X = -3.
   - Required: next step x0 = 636.
   - Mirror case at 0: P0_X = 1, V0_X = -3 → 0, then 3.
4. Handshake:
   - Hold done low 50 cycles in DRAW_WAIT → outputs stable, no new start.
   - Spurious done in HOLD → ignored.
   - start width always 1 cycle.
5. enable dropped during ERASE_WAIT.
   - Required: the erase and draw still complete; IDLE is reached after HOLD; busy = 0.
   - Re-enable → next erase targets the correct oldest slot.
6. reset asserted during DRAW_WAIT.
   - Required: start = 0, busy = 0, endpoints back to the parameter values immediately (async).
   - Required: trail count = 0, so the next step issues a draw without an erase.
